// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 20-bit ALU sequencer.
// Opcodes, FSM states and default widths.
package alu_seq_pkg;

  localparam int ALU_W   = 20;
  localparam int ALU_SHW = 4;

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_ADDC = 4'hB;
  localparam logic [3:0] OP_SUB  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_MOVB = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    RESP
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU: op, a, b, cin -> result, cout, zero, sign.
// ALU_SEQ_BARREL_EN selects full barrel shifts, else 1-bit steps.
module alu_seq_core #(
  parameter int W   = alu_seq_pkg::ALU_W,
  parameter int SHW = alu_seq_pkg::ALU_SHW
) (
  input  logic [3:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
`ifdef ALU_SEQ_BARREL_EN
  input  logic [SHW-1:0] shamt,
`endif
  output logic [W-1:0]   result,
  output logic           cout,
  output logic           zero,
  output logic           sign
);
  import alu_seq_pkg::*;

  logic [W:0] wide;
  logic [W:0] one_w;

  assign one_w = {{W{1'b0}}, 1'b1};

  always_comb begin
    wide   = '0;
    result = '0;
    cout   = cin;
    unique case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
`ifdef ALU_SEQ_BARREL_EN
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_ROL:  result = (a << shamt)
                      | (a >> (W - int'(shamt)));
      OP_ROR:  result = (a >> shamt)
                      | (a << (W - int'(shamt)));
`else
      OP_SHL:  result = {a[W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[W-1:1]};
      OP_ROL:  result = {a[W-2:0], a[W-1]};
      OP_ROR:  result = {a[0], a[W-1:1]};
`endif
      OP_INC: begin
        wide   = {1'b0, a} + one_w;
        result = wide[W-1:0];
        cout   = wide[W];
      end
      // DEC reports a borrow (a==0), like SUB
      OP_DEC: begin
        wide   = {1'b0, a} - one_w;
        result = wide[W-1:0];
        cout   = wide[W];
      end
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        cout   = wide[W];
      end
      OP_ADDC: begin
        wide   = {1'b0, a} + {1'b0, b}
               + {{W{1'b0}}, cin};
        result = wide[W-1:0];
        cout   = wide[W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        cout   = wide[W];
      end
      OP_CMP:  result = '0;
      OP_MOVB: result = b;
      OP_NOP:  result = '0;
      default: result = '0;
    endcase
  end

  assign zero = (op == OP_CMP) ? (a == b)
                               : (result == '0);
  assign sign = (op == OP_CMP) ? (a < b)
                               : result[W-1];

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer around alu_seq_core with sticky carry.
// ALU_SEQ_BARREL_EN: shifts finish in EXEC instead of the SHIFT loop.
module alu_sequencer #(
  parameter int W   = alu_seq_pkg::ALU_W,
  parameter int SHW = alu_seq_pkg::ALU_SHW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [SHW-1:0] req_shamt,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           rsp_sign,
  output logic           rsp_carry,
  output logic           busy
);
  import alu_seq_pkg::*;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   res_q, res_d;
  logic           zero_q, zero_d;
  logic           sign_q, sign_d;

  logic [W-1:0]   c_res;
  logic           c_cout, c_zero, c_sign;

  alu_seq_core #(.W(W), .SHW(SHW)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .cin    (carry_q),
`ifdef ALU_SEQ_BARREL_EN
    .shamt  (cnt_q),
`endif
    .result (c_res),
    .cout   (c_cout),
    .zero   (c_zero),
    .sign   (c_sign)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          cnt_d = req_shamt;
`ifdef ALU_SEQ_BARREL_EN
          state_d = EXEC;
`else
          state_d = is_shift(req_op) ? SHIFT : EXEC;
`endif
        end
      end
      EXEC: begin
        res_d   = c_res;
        zero_d  = c_zero;
        sign_d  = c_sign;
        carry_d = c_cout;
        state_d = RESP;
      end
      // a_q is the working value; core does one bit per cycle
      SHIFT: begin
        if (cnt_q == '0) begin
          res_d   = a_q;
          zero_d  = (a_q == '0);
          sign_d  = a_q[W-1];
          state_d = RESP;
        end else begin
          a_d   = c_res;
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_sign   = sign_q;
  assign rsp_carry  = carry_q;

endmodule
